// File: rtl/spi_slave_rx_tx.sv
// Byte-oriented SPI slave, all four CPOL/CPHA modes, LSB-first in both directions.
// Pins are oversampled on clk; a one-entry buffer feeds transmit bytes for streaming bursts.
module spi_slave_rx_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       s_SCK,
    input  logic       s_SS,
    input  logic       s_MOSI,
    output logic       s_MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        SHIFT      = 2'd2,
        WAIT_DESEL = 2'd3
    } state_t;

    state_t state, state_next;

    logic sck_s1, sck_s2, sck_h;
    logic ss_s1, ss_s2, ss_h;
    logic mosi_s1, mosi_s2;

    logic       sck_rise, sck_fall, ss_fall, ss_rise;
    logic       lead_edge, trail_edge;
    logic [1:0] mode_q;
    logic       first_byte;
    logic       udr_pend;
    logic [7:0] tx_buf;
    logic       buf_full;
    logic       write;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic [2:0] bit_cnt;

    logic latch_mode, load_go, sample_go, drive_go, byte_done, udr_fire;

    // Select flops reset to the "selected" level so a low s_SS at reset release
    // never looks like a fresh fall; the FSM parks in WAIT_DESEL instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_h   <= 1'b0;
            ss_s1   <= 1'b0;
            ss_s2   <= 1'b0;
            ss_h    <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= s_SCK;
            sck_s2  <= sck_s1;
            sck_h   <= sck_s2;
            ss_s1   <= s_SS;
            ss_s2   <= ss_s1;
            ss_h    <= ss_s2;
            mosi_s1 <= s_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise   = sck_s2 & ~sck_h;
    assign sck_fall   = ~sck_s2 & sck_h;
    assign ss_fall    = ~ss_s2 & ss_h;
    assign ss_rise    = ss_s2 & ~ss_h;
    assign lead_edge  = mode_q[1] ? sck_fall : sck_rise;
    assign trail_edge = mode_q[1] ? sck_rise : sck_fall;
    assign rx_next    = {mosi_s2, rx_shift[7:1]};

    assign write    = tx_valid & ~buf_full;
    assign tx_ready = ~buf_full;
    assign busy     = (state == LOAD) || (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_mode = 1'b0;
        load_go    = 1'b0;
        sample_go  = 1'b0;
        drive_go   = 1'b0;
        byte_done  = 1'b0;
        udr_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    latch_mode = 1'b1;
                    state_next = LOAD;
                end else if (!ss_s2) begin
                    state_next = WAIT_DESEL;
                end
            end
            LOAD: begin
                if (ss_rise) begin
                    state_next = IDLE;
                end else begin
                    load_go    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_next = IDLE;
                end else begin
                    // CPHA=0: the trailing edge left over from the previous byte's
                    // last sample arrives with bit_cnt==0 and must not shift.
                    if (!mode_q[0]) begin
                        sample_go = lead_edge;
                        drive_go  = trail_edge && (bit_cnt != 3'd0);
                    end else begin
                        drive_go  = lead_edge;
                        sample_go = trail_edge;
                    end
                    udr_fire = udr_pend && lead_edge;
                    if (sample_go && (bit_cnt == 3'd7)) begin
                        byte_done  = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            WAIT_DESEL: begin
                if (ss_s2) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Underrun on the first byte pulses at select; on later bytes of a burst it is
    // held until the byte really starts, so the LOAD after a burst's final byte is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 2'd0;
            first_byte  <= 1'b0;
            udr_pend    <= 1'b0;
            tx_buf      <= 8'h00;
            buf_full    <= 1'b0;
            tx_shift    <= 8'h00;
            rx_shift    <= 8'h00;
            bit_cnt     <= 3'd0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            s_MISO      <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (latch_mode) begin
                mode_q     <= mode;
                first_byte <= 1'b1;
            end

            if (write) begin
                tx_buf <= tx_data;
            end
            if (load_go) begin
                buf_full <= write;
            end else if (write) begin
                buf_full <= 1'b1;
            end

            if (load_go) begin
                tx_shift <= buf_full ? tx_buf : 8'h00;
                bit_cnt  <= 3'd0;
                if (!buf_full) begin
                    if (first_byte) begin
                        tx_underrun <= 1'b1;
                    end else begin
                        udr_pend <= 1'b1;
                    end
                end
                if (!mode_q[0]) begin
                    s_MISO <= buf_full ? tx_buf[0] : 1'b0;
                end
            end

            if (udr_fire) begin
                tx_underrun <= 1'b1;
                udr_pend    <= 1'b0;
            end

            if (drive_go) begin
                s_MISO   <= mode_q[0] ? tx_shift[0] : tx_shift[1];
                tx_shift <= {1'b0, tx_shift[7:1]};
            end

            if (sample_go) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                first_byte <= 1'b0;
            end

            if ((state_next == IDLE) || (state_next == WAIT_DESEL)) begin
                s_MISO   <= 1'b0;
                udr_pend <= 1'b0;
                bit_cnt  <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: a bit-level SPI master model, a tx feeder and an rx scoreboard.
module tb_spi_slave_rx_tx;

    localparam int H = 8;  // SCK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       s_SCK = 1'b0;
    logic       s_SS = 1'b1;
    logic       s_MOSI = 1'b0;
    logic       s_MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    spi_slave_rx_tx dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .s_SCK       (s_SCK),
        .s_SS        (s_SS),
        .s_MOSI      (s_MOSI),
        .s_MISO      (s_MISO),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         rx_cnt = 0;
    int         udr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rx = 8'h00;
    logic [1:0] cur_mode = 2'd0;
    logic [7:0] mb[4];
    logic [7:0] sb[4];
    logic [7:0] got[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_valid), 32'd0);
            else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (!rst && tx_underrun) udr_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        int t;
        t = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master side of one byte: drives MOSI LSB first and samples MISO on its sampling edge.
    task automatic shift_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = cur_mode[1];
        cpha = cur_mode[0];
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                s_MOSI = mo[i];
                wait_clks(H);
                mi[i] = s_MISO;
                s_SCK = ~cpol;
                wait_clks(H);
                s_SCK = cpol;
            end else begin
                wait_clks(H);
                s_SCK = ~cpol;
                s_MOSI = mo[i];
                wait_clks(H);
                mi[i] = s_MISO;
                s_SCK = cpol;
            end
        end
    endtask

    // One select: n_full whole bytes, optionally a partial byte, the first p slave bytes supplied.
    task automatic run_txn(input logic [1:0] m, input int n_full, input int part_bits, input int p);
        int nb, rx0, u0, bits;
        logic [7:0] mask, exp_b;
        nb = n_full + ((part_bits > 0) ? 1 : 0);
        cur_mode = m;
        mode = m;
        s_SCK = m[1];
        wait_clks(4);
        rx0 = rx_cnt;
        u0 = udr_cnt;
        for (int k = 0; k < n_full; k++) exp_q.push_back(mb[k]);
        fork
            begin
                for (int k = 0; k < p; k++) write_tx(sb[k]);
            end
            begin
                wait_clks(2);
                s_SS = 1'b0;
                for (int k = 0; k < nb; k++) shift_byte(mb[k], (k < n_full) ? 8 : part_bits, got[k]);
                wait_clks(H);
                s_SS = 1'b1;
                wait_clks(H);
            end
        join
        for (int k = 0; k < nb; k++) begin
            bits  = (k < n_full) ? 8 : part_bits;
            mask  = 8'((1 << bits) - 1);
            exp_b = (k < p) ? sb[k] : 8'h00;
            check("miso_byte", 32'(got[k] & mask), 32'(exp_b & mask));
        end
        if (n_full > 0) last_rx = mb[n_full-1];
        check("rx_count", 32'(rx_cnt - rx0), 32'(n_full));
        check("underrun_count", 32'(udr_cnt - u0), 32'(nb - p));
        check("rx_hold", 32'(rx_data), 32'(last_rx));
        check("busy_idle", 32'(busy), 32'd0);
        check("miso_idle", 32'(s_MISO), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, 32'(s_MISO), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] tmp;
        int u0, nf, pb, nb;

        // Clock/reset
        rst = 1'b1;
        wait_clks(5);
        check_reset_values("reset");
        rst = 1'b0;
        wait_clks(5);
        check_reset_values("post_reset");

        // Mode 0 single exchange
        mb[0] = 8'h3C; sb[0] = 8'hA5;
        run_txn(2'd0, 1, 0, 1);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            mb[0] = 8'h96; sb[0] = 8'h69;
            run_txn(2'(m), 1, 0, 1);
        end

        // Mode 0 burst with feeder
        mb[0] = 8'hC1; mb[1] = 8'h5E; mb[2] = 8'h7A;
        sb[0] = 8'h11; sb[1] = 8'h22; sb[2] = 8'h33;
        run_txn(2'd0, 3, 0, 3);

        // Empty buffer at select
        mb[0] = 8'h5A;
        run_txn(2'd0, 1, 0, 0);

        // Abort after 5 bits, then a full transfer
        mb[0] = 8'hE7; sb[0] = 8'h4B;
        run_txn(2'd0, 0, 5, 1);
        mb[0] = 8'hD2; sb[0] = 8'h2D;
        run_txn(2'd1, 1, 0, 1);

        // Reset mid-byte with select held low
        cur_mode = 2'd0; mode = 2'd0; s_SCK = 1'b0;
        wait_clks(4);
        write_tx(8'h55);
        s_SS = 1'b0;
        wait_clks(6);
        write_tx(8'h66);
        shift_byte(8'hF0, 4, tmp);
        rst = 1'b1;
        wait_clks(3);
        check_reset_values("mid_reset");
        rst = 1'b0;
        last_rx = 8'h00;
        u0 = udr_cnt;
        shift_byte(8'hAA, 8, tmp);
        wait_clks(H);
        check("held_sel_busy", 32'(busy), 32'd0);
        check("held_sel_underrun", 32'(udr_cnt - u0), 32'd0);
        check("held_sel_rx_data", 32'(rx_data), 32'd0);
        s_SS = 1'b1;
        wait_clks(2 * H);
        mb[0] = 8'h81; sb[0] = 8'h7E;
        run_txn(2'd0, 1, 0, 1);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            nf = $urandom_range(1, 3);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            nb = nf + ((pb > 0) ? 1 : 0);
            for (int k = 0; k < 4; k++) begin
                mb[k] = 8'($urandom_range(0, 255));
                sb[k] = 8'($urandom_range(0, 255));
            end
            run_txn(2'($urandom_range(0, 3)), nf, pb, $urandom_range(0, nb));
        end

        wait_clks(10);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
